adc_sample_averager: RTL and testbench

Downstream consumer of the serial ADC interface: captures each completed 10-bit conversion (`data_out` qualified by `done`), accumulates a block of 2^LOG2_N samples, and presents the truncated block average on a valid/ready output port. It decimates the ADC stream by N and decouples the next stage from conversion timing. Results that cannot be delivered are dropped, and a sticky overrun flag is set.

---
 rtl/adc_sample_averager.sv | 185 ++++++++++++++++++
 tb/tb_adc_sample_averager.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_averager.sv
// adc_sample_averager: block-averages ADC conversions onto a valid/ready port.
// Optional block min/max outputs are enabled by defining ADC_AVG_MINMAX_EN.
module adc_sample_averager #(
  parameter int DATA_W = 10,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
`ifdef ADC_AVG_MINMAX_EN
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
`endif
  output logic              overrun
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int N     = 1 << LOG2_N;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_done_q;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [DATA_W-1:0] r_avg;
  logic              r_overrun;

  logic              w_take;
  logic              w_last;
  logic              w_xfer;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_avg;

`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_omin;
  logic [DATA_W-1:0] r_omax;
  logic [DATA_W-1:0] w_bmin;
  logic [DATA_W-1:0] w_bmax;
  logic              w_first;
`endif

  // Sample strobe, block-end detect and the truncated block average.
  always_comb begin
    w_take = in_done && !r_done_q && !clear;
    w_last = w_take && (r_cnt == CNT_LAST);
    w_xfer = r_valid && out_ready;
    w_sum  = r_acc + ACC_W'(in_data);
    w_avg  = DATA_W'(w_sum >> LOG2_N);
  end

`ifdef ADC_AVG_MINMAX_EN
  // Running extremes including the sample being taken this cycle.
  always_comb begin
    w_first = (r_cnt == '0);
    w_bmin  = r_min;
    w_bmax  = r_max;
    if (w_first || (in_data < r_min)) begin
      w_bmin = in_data;
    end
    if (w_first || (in_data > r_max)) begin
      w_bmax = in_data;
    end
  end
`endif

  // Rising-edge history of in_done; keeps updating during clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= in_done;
    end
  end

  // Block accumulator and sample counter; a block end restarts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_last) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  // Running min/max; the first sample of each block reseeds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (clear) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_take) begin
      r_min <= w_bmin;
      r_max <= w_bmax;
    end
  end
`endif

  // Output holding register: EMPTY/FULL with sticky overrun on a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_EMPTY;
      r_valid   <= 1'b0;
      r_avg     <= '0;
      r_overrun <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      r_omin    <= '0;
      r_omax    <= '0;
`endif
    end else if (clear) begin
      r_state   <= S_EMPTY;
      r_valid   <= 1'b0;
      r_avg     <= '0;
      r_overrun <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      r_omin    <= '0;
      r_omax    <= '0;
`endif
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_last) begin
            r_state <= S_FULL;
            r_valid <= 1'b1;
            r_avg   <= w_avg;
`ifdef ADC_AVG_MINMAX_EN
            r_omin  <= w_bmin;
            r_omax  <= w_bmax;
`endif
          end
        end
        S_FULL: begin
          if (w_last && w_xfer) begin
            r_avg   <= w_avg;
`ifdef ADC_AVG_MINMAX_EN
            r_omin  <= w_bmin;
            r_omax  <= w_bmax;
`endif
          end else if (w_last) begin
            r_overrun <= 1'b1;
          end else if (w_xfer) begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_avg   = r_avg;
  assign overrun   = r_overrun;
`ifdef ADC_AVG_MINMAX_EN
  assign out_min   = r_omin;
  assign out_max   = r_omax;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: scoreboard bench with a queue-based reference
// model of block averaging, output holding and overrun.
module tb_adc_sample_averager;

  localparam int DW = 10;
  localparam int LN = 3;
  localparam int N  = 1 << LN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_done;
  logic [DW-1:0] in_data;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_avg;
  logic          overrun;
`ifdef ADC_AVG_MINMAX_EN
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_max;
`endif

  adc_sample_averager #(.DATA_W(DW), .LOG2_N(LN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_done   (in_done),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
`ifdef ADC_AVG_MINMAX_EN
    .out_min   (out_min),
    .out_max   (out_max),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    int mn;
    int mx;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  int   samp_q[$];
  bit   m_prev;
  bit   m_full;
  bit   m_ovr;
  bit   rnd_ready;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: one step per rising edge, from the block rules.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev = 1'b0;
      m_full = 1'b0;
      m_ovr  = 1'b0;
      samp_q.delete();
      exp_q.delete();
    end else begin
      if (clear) begin
        m_full = 1'b0;
        m_ovr  = 1'b0;
        samp_q.delete();
        exp_q.delete();
      end else begin
        if (m_full && out_ready) m_full = 1'b0;
        if (in_done && !m_prev) begin
          samp_q.push_back(int'(in_data));
          if (samp_q.size() == N) begin
            res_t r;
            int   s;
            s    = 0;
            r.mn = samp_q[0];
            r.mx = samp_q[0];
            foreach (samp_q[k]) begin
              s += samp_q[k];
              if (samp_q[k] < r.mn) r.mn = samp_q[k];
              if (samp_q[k] > r.mx) r.mx = samp_q[k];
            end
            r.avg = s / N;
            samp_q.delete();
            if (!m_full) begin
              exp_q.push_back(r);
              m_full = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end
        end
      end
      m_prev = in_done;
    end
  end

  // Monitor: mid-cycle compare of status and of every delivered result.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_avg", int'(out_avg), 0);
      chk("rst_overrun", int'(overrun), 0);
`ifdef ADC_AVG_MINMAX_EN
      chk("rst_min", int'(out_min), 0);
      chk("rst_max", int'(out_max), 0);
`endif
    end else begin
      chk("valid", int'(out_valid), int'(m_full));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (out_valid && out_ready && !clear) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("avg", int'(out_avg), e.avg);
`ifdef ADC_AVG_MINMAX_EN
          chk("min", int'(out_min), e.mn);
          chk("max", int'(out_max), e.mx);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int d, input int hi, input int lo);
    in_data = DW'(d);
    in_done = 1'b1;
    repeat (hi) tick();
    in_done = 1'b0;
    in_data = DW'($urandom);
    repeat (lo) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_done   = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    rnd_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full-scale block.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send('h3FF, 1, 1);
    tick();
    chk("fullscale_drained", exp_q.size(), 0);

    // Ramp 0..7.
    for (int i = 0; i < N; i++) send(i, 1, 1);
    tick();

    // Long level pulses; one 9-cycle pulse is one sample.
    for (int i = 0; i < N; i++) send(40 + i, 5, 2);
    send(5, 9, 1);
    chk("long_pulse_cnt", samp_q.size(), 1);
    pulse_clear();

    // Two blocks with no consumer: second block is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send('h100, 1, 1);
    for (int i = 0; i < N; i++) send('h200, 1, 1);
    @(negedge clk);
    chk("ovr_hold_avg", int'(out_avg), 'h100);
    chk("ovr_flag", int'(overrun), 1);
    #2;
    out_ready = 1'b1;
    tick();
    tick();
    chk("ovr_drained", int'(out_valid), 0);
    pulse_clear();
    chk("ovr_cleared", int'(overrun), 0);

    // Completion with transfer in the same cycle while FULL.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send('h050, 1, 1);
    for (int i = 0; i < N - 1; i++) send('h060, 1, 1);
    out_ready = 1'b1;
    send('h060, 1, 1);
    chk("swap_avg", int'(out_avg), 'h060);
    chk("swap_no_ovr", int'(overrun), 0);
    tick();

    // Reset mid-block, then a fresh block.
    for (int i = 0; i < 5; i++) send('h3A0, 1, 1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) send('h010, 1, 1);
    chk("post_rst_avg", int'(out_avg), 'h010);
    tick();

    // Randomized traffic with a stalling consumer and occasional clear.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 1023), $urandom_range(1, 4),
           $urandom_range(1, 3));
      if ($urandom_range(0, 60) == 0) begin
        clear   = 1'b1;
        in_done = ($urandom_range(0, 1) == 1);
        tick();
        clear = 1'b0;
        tick();
        in_done = 1'b0;
        tick();
      end
    end

    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
